// File: rtl/sub_serial_tx.sv
// sub_serial_tx: single-line serial frame transmitter.
// Takes a parallel word over a valid/ready handshake and sends it LSB-first
// as start, data, [parity], stop, with each bit held for CLKS_PER_BIT clocks.
// Optional even parity bit: define SUB_SERIAL_TX_PARITY_EN to insert it
// after the data bits. The default build has no parity state or logic.
// All outputs are registered so TXD is glitch-free for the clocked receiver.

module sub_serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] DIN,
  input  logic              DIN_VALID,
  output logic              DIN_READY,
  output logic              TXD,
  output logic              BUSY,
  output logic              DONE
);

  // Cycle counter is at least one bit wide, even when CLKS_PER_BIT is 1.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_W + 1);

  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(DATA_W - 1);

`ifdef SUB_SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;
`endif

  state_t            r_state;
  logic [DATA_W-1:0] r_shift;
  logic [CW-1:0]     r_cycleCnt;
  logic [BW-1:0]     r_bitCnt;
  logic [DATA_W-1:0] w_shiftNext;
  logic              w_bitEnd;
`ifdef SUB_SERIAL_TX_PARITY_EN
  logic              r_parity;
`endif

  // Next shift-register contents and end-of-bit strobe, shared by all states.
  assign w_shiftNext = r_shift >> 1;
  assign w_bitEnd    = (r_cycleCnt == CNT_MAX);

  // Frame sequencer; every output is loaded one cycle ahead so it is registered.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_cycleCnt <= '0;
      r_bitCnt   <= '0;
`ifdef SUB_SERIAL_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
      TXD        <= 1'b1;
      DIN_READY  <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          TXD       <= 1'b1;
          BUSY      <= 1'b0;
          DONE      <= 1'b0;
          DIN_READY <= 1'b1;
          if (DIN_VALID && DIN_READY) begin
            r_shift    <= DIN;
`ifdef SUB_SERIAL_TX_PARITY_EN
            r_parity   <= ^DIN;
`endif
            r_cycleCnt <= '0;
            r_bitCnt   <= '0;
            r_state    <= S_START;
            TXD        <= 1'b0;
            BUSY       <= 1'b1;
            DIN_READY  <= 1'b0;
          end
        end

        S_START: begin
          if (w_bitEnd) begin
            r_cycleCnt <= '0;
            r_state    <= S_DATA;
            TXD        <= r_shift[0];
          end else begin
            r_cycleCnt <= r_cycleCnt + 1'b1;
          end
        end

        S_DATA: begin
          if (w_bitEnd) begin
            r_cycleCnt <= '0;
            if (r_bitCnt == BIT_MAX) begin
`ifdef SUB_SERIAL_TX_PARITY_EN
              r_state <= S_PARITY;
              TXD     <= r_parity;
`else
              r_state <= S_STOP;
              TXD     <= 1'b1;
`endif
            end else begin
              r_bitCnt <= r_bitCnt + 1'b1;
              r_shift  <= w_shiftNext;
              TXD      <= w_shiftNext[0];
            end
          end else begin
            r_cycleCnt <= r_cycleCnt + 1'b1;
          end
        end

`ifdef SUB_SERIAL_TX_PARITY_EN
        S_PARITY: begin
          if (w_bitEnd) begin
            r_cycleCnt <= '0;
            r_state    <= S_STOP;
            TXD        <= 1'b1;
          end else begin
            r_cycleCnt <= r_cycleCnt + 1'b1;
          end
        end
`endif

        S_STOP: begin
          if (w_bitEnd) begin
            r_cycleCnt <= '0;
            r_state    <= S_IDLE;
            TXD        <= 1'b1;
            BUSY       <= 1'b0;
            DIN_READY  <= 1'b1;
            DONE       <= 1'b1;
          end else begin
            r_cycleCnt <= r_cycleCnt + 1'b1;
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_cycleCnt <= '0;
          TXD        <= 1'b1;
          BUSY       <= 1'b0;
          DIN_READY  <= 1'b0;
          DONE       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_serial_tx.sv
// tb_sub_serial_tx: self-checking bench for sub_serial_tx.
// A behavioural frame model builds the expected bit list for each word and
// every output is compared cycle by cycle on the falling clock edge.
// Build with SUB_SERIAL_TX_PARITY_EN to exercise the parity variant (1 clk/bit).

module tb_sub_serial_tx;

  localparam int DW = 8;
`ifdef SUB_SERIAL_TX_PARITY_EN
  localparam int CPB = 1;
`else
  localparam int CPB = 4;
`endif

  logic          clock = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic          dinValid;
  logic          dinReady;
  logic          txd;
  logic          busy;
  logic          done;

  int nChecks = 0;
  int nFails  = 0;
  bit expBits[$];

  sub_serial_tx #(
    .DATA_W       (DW),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .CLK       (clock),
    .RST       (rst),
    .DIN       (din),
    .DIN_VALID (dinValid),
    .DIN_READY (dinReady),
    .TXD       (txd),
    .BUSY      (busy),
    .DONE      (done)
  );

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  // One comparison: counted, asserted, and reported on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line levels for one frame: start, data LSB first, [even parity], stop.
  function automatic void buildFrame(input logic [DW-1:0] w);
    expBits.delete();
    expBits.push_back(1'b0);
    for (int i = 0; i < DW; i++) expBits.push_back(bit'((w >> i) & 1));
`ifdef SUB_SERIAL_TX_PARITY_EN
    expBits.push_back(bit'($countones(w) % 2));
`endif
    expBits.push_back(1'b1);
  endfunction

  // Quiet idle cycle expectations.
  task automatic checkIdle(input string tag);
    @(negedge clock);
    checkOutput({tag, "_txd"},  txd,  1);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_rdy"},  dinReady, 1);
  endtask

  // Send one word from a ready cycle and check every cycle through the DONE cycle.
  // keepValid/nextWord drive the source after accept; pulseCycle injects a stray valid.
  task automatic applyStimulus(input logic [DW-1:0] word, input bit keepValid,
                               input logic [DW-1:0] nextWord, input int pulseCycle);
    int nCyc;
    din      = word;
    dinValid = 1'b1;
    checkOutput($sformatf("rdy_pre_%02h", word), dinReady, 1);
    buildFrame(word);
    nCyc = expBits.size() * CPB;
    for (int c = 1; c <= nCyc; c++) begin
      @(negedge clock);
      if (c == 1) begin
        dinValid = keepValid;
        din      = nextWord;
      end
      if (c == pulseCycle) begin
        dinValid = 1'b1;
        din      = '0;
      end else if (c == pulseCycle + 1) begin
        dinValid = keepValid;
      end
      checkOutput($sformatf("txd_%02h_c%0d", word, c), txd, expBits[(c - 1) / CPB]);
      checkOutput($sformatf("busy_%02h_c%0d", word, c), busy, 1);
      checkOutput($sformatf("rdy_%02h_c%0d", word, c), dinReady, 0);
      checkOutput($sformatf("done_%02h_c%0d", word, c), done, 0);
    end
    @(negedge clock);
    checkOutput($sformatf("done_%02h_end", word), done, 1);
    checkOutput($sformatf("rdy_%02h_end", word), dinReady, 1);
    checkOutput($sformatf("busy_%02h_end", word), busy, 0);
    checkOutput($sformatf("txd_%02h_end", word), txd, 1);
  endtask

  initial begin
    int resetCycle;
    int gap;
    logic [DW-1:0] w;

    // Reset held with a word offered: nothing may start.
    rst      = 1'b0;
    dinValid = 1'b1;
    din      = 8'hA5;
    repeat (3) begin
      @(negedge clock);
      checkOutput("rst_txd",  txd,      1);
      checkOutput("rst_rdy",  dinReady, 0);
      checkOutput("rst_busy", busy,     0);
      checkOutput("rst_done", done,     0);
    end
    rst = 1'b1;
    @(negedge clock);
    checkOutput("post_rst_rdy",  dinReady, 1);
    checkOutput("post_rst_txd",  txd,      1);
    checkOutput("post_rst_busy", busy,     0);

    // Single frame, valid still held from reset.
    applyStimulus(8'hA5, 1'b0, 8'h00, 0);
    checkIdle("gap_a5");

    // Back-to-back: valid stays high so the second accept lands in the DONE cycle.
    applyStimulus(8'h01, 1'b1, 8'hFF, 0);
    applyStimulus(8'hFF, 1'b0, 8'h00, 0);
    checkIdle("gap_ff");

    // Stray valid during DATA must not disturb the frame or start another.
    applyStimulus(8'h3C, 1'b0, 8'h00, CPB * 3 + 2);
    checkIdle("ign1");
    checkIdle("ign2");

    // Odd parity-weight word.
    applyStimulus(8'h07, 1'b0, 8'h00, 0);
    checkIdle("gap_07");

    // Reset during data bit 3: line returns high at once and no DONE follows.
    buildFrame(8'h3C);
    din        = 8'h3C;
    dinValid   = 1'b1;
    resetCycle = CPB * 4 + 1;
    for (int c = 1; c <= resetCycle; c++) begin
      @(negedge clock);
      if (c == 1) dinValid = 1'b0;
      checkOutput($sformatf("mid_txd_c%0d", c), txd, expBits[(c - 1) / CPB]);
    end
    #2 rst = 1'b0;
    #1;
    checkOutput("mid_rst_txd",  txd,      1);
    checkOutput("mid_rst_busy", busy,     0);
    checkOutput("mid_rst_rdy",  dinReady, 0);
    checkOutput("mid_rst_done", done,     0);
    repeat (3) begin
      @(negedge clock);
      checkOutput("mid_hold_done", done, 0);
      checkOutput("mid_hold_txd",  txd,  1);
    end
    rst = 1'b1;
    @(negedge clock);
    checkOutput("mid_rel_done", done,     0);
    checkOutput("mid_rel_rdy",  dinReady, 1);
    applyStimulus(8'h5A, 1'b0, 8'h00, 0);

    // Random words with random idle gaps.
    for (int k = 0; k < 6; k++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) checkIdle("rnd_gap");
      w = DW'($urandom);
      applyStimulus(w, 1'b0, DW'($urandom), 0);
    end
    checkIdle("final");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/sub_serial_tx.md
Name: sub_serial_tx

Overview:
- Single-line serial frame transmitter. It is the driving end of the one-bit IN line that the SUB/SUB2 style receiver blocks sample on CLK.
- Accepts a parallel word over a valid/ready handshake and shifts it out LSB-first as a framed bit stream: start, data, [parity], stop.
- Each bit is held for a programmable number of CLK cycles.
- Sits between a register/control source inside TOP and the serial IN port of a submodule instance.

Parameters:
- DATA_W, 8: data bits per frame; legal values are 1 or more.
- CLKS_PER_BIT, 4: CLK cycles each serial bit is held on TXD; legal values are 1 or more.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset, asynchronous, active-low.
- DIN  input  DATA_W  parallel word to send; sampled only on accept.
- DIN_VALID  input  1  source has a word on DIN.
- DIN_READY  output  1  transmitter can accept a word this cycle.
- TXD  output  1  serial line; idle level is 1.
- BUSY  output  1  a frame is in flight.
- DONE  output  1  one-cycle pulse when a frame's stop bit has completed.

Behaviour:
- Reset is asynchronous. While RST=0:
  - TXD=1, DIN_READY=0, BUSY=0, DONE=0.
  - State=IDLE; shift register, bit counter and cycle counter cleared.
- First rising CLK after RST deasserts: DIN_READY=1 in IDLE.
- States: IDLE, START, DATA, [PARITY], STOP.
- IDLE:
  - TXD=1, DIN_READY=1, BUSY=0.
  - Accept occurs when DIN_VALID=1 && DIN_READY=1 on a rising edge. On accept: latch DIN into the shift register and go to START.
  - DIN_VALID while not in IDLE is ignored; DIN is not sampled.
- START: TXD=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - TXD = shift register bit 0, held for CLKS_PER_BIT cycles.
  - Then shift right by one and increment the bit counter.
  - After DATA_W bits, go to PARITY if compiled in, otherwise to STOP.
- STOP: TXD=1 for CLKS_PER_BIT cycles, then return to IDLE.
- DONE: asserted for exactly the first IDLE cycle after STOP.
  - DIN_READY=1 in that same cycle, so a held DIN_VALID is accepted there.
  - Minimum gap between frames is therefore 1 idle CLK at TXD=1.
- Timing:
  - Accept is at edge E0. TXD=0 is visible from the cycle after E0.
  - Frame length is (DATA_W+2[+1]) * CLKS_PER_BIT cycles.
- Signals outside IDLE: BUSY=1 and DIN_READY=0 in every non-IDLE state.
- Counters:
  - Cycle counter is $clog2(CLKS_PER_BIT) bits wide, minimum 1 bit.
  - It counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Bit counter is $clog2(DATA_W+1) bits wide.
  - No counter may overflow for any legal parameter value.
- CLKS_PER_BIT=1: each bit lasts exactly one cycle; no extra stall cycles.
- Reset mid-frame: TXD returns to 1 immediately (asynchronously) and the frame is abandoned. No DONE is generated.
- All outputs are registered. TXD must be glitch-free because it feeds another clocked block directly.

Optional Feature:
- Macro: SUB_SERIAL_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted after DATA.
  - TXD = XOR of all DATA_W latched bits (even parity), held for CLKS_PER_BIT cycles.
  - Frame length becomes (DATA_W+3) * CLKS_PER_BIT.
- Undefined: no PARITY state and no parity logic; DATA goes directly to STOP.

Test Plan:
- Reset values: hold RST=0 with DIN_VALID=1 -> TXD=1, DIN_READY=0, BUSY=0, DONE=0. Release RST -> DIN_READY=1 on the first edge, and no frame starts until that accept edge.
- Single frame: DATA_W=8, CLKS_PER_BIT=4, DIN=8'hA5 accepted at E0 -> TXD carries 0,1,0,1,0,0,1,0,1,1, each bit for 4 cycles (40 cycles total).
  - BUSY=1 for those 40 cycles.
  - DONE=1 in cycle 41 only.
- Back-to-back: DIN_VALID held high with 8'h01 then 8'hFF -> second accept occurs in the DONE cycle. Exactly one TXD=1 idle cycle separates the stop bit from the next start bit.
- Ignored valid: pulse DIN_VALID with 8'h00 during the DATA state of an 8'h3C frame -> the 8'h3C frame is unchanged and no second frame is sent.
- Reset mid-frame: assert RST=0 during DATA bit 3 -> TXD=1 in the same cycle and DONE never pulses. After release, 8'h5A transmits correctly.
- Parity build: SUB_SERIAL_TX_PARITY_EN defined, CLKS_PER_BIT=1.
  - 8'hA5 -> parity bit 0; 8'h07 -> parity bit 1.
  - Frame is 11 cycles; DONE appears at cycle 12.
